// File: rtl/joy_answer_arbiter.sv
// rtl/joy_answer_arbiter.sv - two-player joystick sync/debounce/encode with first-press-wins arbitration.
// One joy_answer_debounce per stick feeds a WAIT_RELEASE/ARMED/LOCKED round FSM.

module joy_answer_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pins_i,
  output logic       released_o,
  output logic       new_press_o,
  output logic [2:0] code_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [3:0]    meta_q, sync_q, prev_q, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_step;
  logic [2:0]    code_prev_q;
  logic [1:0]    fill_q;
  logic          rel_ok_q, rel_ok_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= 4'b1111;
      sync_q      <= 4'b1111;
      prev_q      <= 4'b1111;
      stable_q    <= 4'b1111;
      cnt_q       <= '0;
      code_prev_q <= 3'd0;
      fill_q      <= 2'd0;
      rel_ok_q    <= 1'b0;
    end else begin
      meta_q      <= pins_i;
      sync_q      <= meta_q;
      prev_q      <= sync_q;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      code_prev_q <= code_o;
      fill_q      <= (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      rel_ok_q    <= rel_ok_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    cnt_step = (sync_q != prev_q) ? CW'(1) : cnt_q + CW'(1);
    if (sync_q != stable_q) begin
      if (cnt_step == CNT_MAX) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_step;
      end
    end
  end

  // A stick only becomes eligible once the filled sync pipe has shown it released,
  // so a press held through reset cannot score.
  assign rel_ok_d = rel_ok_q | ((fill_q == 2'd2) && (sync_q == 4'b1111));

  always_comb begin
    code_o = 3'd0;
    case (stable_q)
      4'b1110: code_o = 3'd1;
      4'b1101: code_o = 3'd2;
      4'b1011: code_o = 3'd3;
      4'b0111: code_o = 3'd4;
      default: code_o = 3'd0;
    endcase
  end

  assign released_o  = (stable_q == 4'b1111);
  assign new_press_o = rel_ok_q && (code_prev_q == 3'd0) && (code_o != 3'd0);

endmodule

module joy_answer_arbiter #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] joyInL,
  input  logic [3:0] joyInR,
  input  logic       round_done,
  output logic       ans_valid,
  output logic       ans_player,
  output logic [2:0] ans_choice,
  output logic       armed
);

  typedef enum logic [1:0] {WAIT_RELEASE, ARMED, LOCKED} state_e;

  state_e     state_q, state_d;
  logic       valid_q, valid_d;
  logic       player_q, player_d;
  logic [2:0] choice_q, choice_d;
  logic       prio_q, prio_d;

  logic       rel_l, rel_r, press_l, press_r;
  logic [2:0] code_l, code_r;

  joy_answer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk        (clk),
    .rst_n      (rst_n),
    .pins_i     (joyInL),
    .released_o (rel_l),
    .new_press_o(press_l),
    .code_o     (code_l)
  );

  joy_answer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk        (clk),
    .rst_n      (rst_n),
    .pins_i     (joyInR),
    .released_o (rel_r),
    .new_press_o(press_r),
    .code_o     (code_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_RELEASE;
      valid_q  <= 1'b0;
      player_q <= 1'b0;
      choice_q <= 3'd0;
      prio_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      player_q <= player_d;
      choice_q <= choice_d;
      prio_q   <= prio_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    player_d = player_q;
    choice_d = choice_q;
    prio_d   = prio_q;
    case (state_q)
      WAIT_RELEASE: begin
        if (rel_l && rel_r) state_d = ARMED;
      end
      ARMED: begin
        if (press_l && press_r) begin
          // Tie: priority bit decides, then alternates for fairness.
          valid_d  = 1'b1;
          player_d = prio_q;
          choice_d = prio_q ? code_r : code_l;
          prio_d   = ~prio_q;
          state_d  = LOCKED;
        end else if (press_l) begin
          valid_d  = 1'b1;
          player_d = 1'b0;
          choice_d = code_l;
          state_d  = LOCKED;
        end else if (press_r) begin
          valid_d  = 1'b1;
          player_d = 1'b1;
          choice_d = code_r;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (round_done) state_d = WAIT_RELEASE;
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

  assign ans_valid  = valid_q;
  assign ans_player = player_q;
  assign ans_choice = choice_q;
  assign armed      = (state_q == ARMED);

endmodule

// File: tb/tb_joy_answer_arbiter.sv
// tb/tb_joy_answer_arbiter.sv - directed self-checking bench for joy_answer_arbiter, DEBOUNCE_CYCLES=4.

module tb_joy_answer_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] joyInL;
  logic [3:0] joyInR;
  logic       round_done;
  logic       ans_valid;
  logic       ans_player;
  logic [2:0] ans_choice;
  logic       armed;

  int tests = 0;
  int fails = 0;
  int e;
  int n;

  joy_answer_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .joyInL    (joyInL),
    .joyInR    (joyInR),
    .round_done(round_done),
    .ans_valid (ans_valid),
    .ans_player(ans_player),
    .ans_choice(ans_choice),
    .armed     (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int edge_n);
    edge_n = 0;
    for (int i = 1; i <= max && edge_n == 0; i++) begin
      tick();
      if (ans_valid === 1'b1) edge_n = i;
    end
  endtask

  task automatic wait_armed(input int max, output int edge_n);
    edge_n = 0;
    for (int i = 1; i <= max && edge_n == 0; i++) begin
      tick();
      if (armed === 1'b1) edge_n = i;
    end
  endtask

  task automatic count_valid(input int k, output int cnt);
    cnt = 0;
    for (int i = 0; i < k; i++) begin
      tick();
      if (ans_valid !== 1'b0) cnt++;
    end
  endtask

  task automatic pulse_round_done();
    round_done = 1'b1;
    tick();
    round_done = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    joyInL     = 4'b1111;
    joyInR     = 4'b1111;
    round_done = 1'b0;
    ticks(3);
    check("rst_valid",  ans_valid,  0);
    check("rst_player", ans_player, 0);
    check("rst_choice", ans_choice, 0);
    check("rst_armed",  armed,      0);

    rst_n = 1'b1;
    tick();
    check("armed_first_edge", armed, 1);
    ticks(3);

    // Clean single press on the left
    joyInL = 4'b1011;
    wait_valid(20, e);
    check("s1_latency", e, 7);
    check("s1_player", ans_player, 0);
    check("s1_choice", ans_choice, 3);
    check("s1_armed_low", armed, 0);
    tick();
    check("s1_pulse_width", ans_valid, 0);
    check("s1_choice_held", ans_choice, 3);

    joyInL = 4'b1111;
    pulse_round_done();
    ticks(10);
    check("s2_rearmed", armed, 1);

    // 3-cycle glitches on right bit0 must never debounce
    n = 0;
    for (int i = 0; i < 40; i++) begin
      joyInR[0] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (ans_valid !== 1'b0) n++;
    end
    joyInR = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ans_valid !== 1'b0) n++;
    end
    check("s2_glitch_no_valid", n, 0);
    check("s2_glitch_stable", dut.u_right.stable_q, 4'b1111);
    check("s2_still_armed", armed, 1);

    // Simultaneous tie: left wins first, then right
    joyInL = 4'b1110;
    joyInR = 4'b0111;
    wait_valid(20, e);
    check("s3_tie1_latency", e, 7);
    check("s3_tie1_player", ans_player, 0);
    check("s3_tie1_choice", ans_choice, 1);
    joyInL = 4'b1111;
    joyInR = 4'b1111;
    pulse_round_done();
    ticks(10);
    check("s3_rearmed", armed, 1);
    joyInL = 4'b1110;
    joyInR = 4'b0111;
    wait_valid(20, e);
    check("s3_tie2_latency", e, 7);
    check("s3_tie2_player", ans_player, 1);
    check("s3_tie2_choice", ans_choice, 4);

    // Presses while locked are ignored; round_done with a held stick stays disarmed
    joyInL = 4'b1111;
    joyInR = 4'b1111;
    ticks(10);
    joyInR = 4'b1101;
    count_valid(10, n);
    check("s4_locked_no_valid", n, 0);
    pulse_round_done();
    ticks(10);
    check("s4_held_not_armed", armed, 0);
    joyInR = 4'b1111;
    wait_armed(20, e);
    check("s4_rearm_edges", e, 7);
    joyInR = 4'b1101;
    wait_valid(20, e);
    check("s4_latency", e, 7);
    check("s4_player", ans_player, 1);
    check("s4_choice", ans_choice, 2);

    // Two-bits-low pattern: no answer, and blocks re-arming
    joyInL = 4'b1100;
    joyInR = 4'b1111;
    ticks(10);
    pulse_round_done();
    count_valid(15, n);
    check("s5_multi_no_valid", n, 0);
    check("s5_multi_not_armed", armed, 0);
    joyInL = 4'b1111;
    wait_armed(20, e);
    check("s5_rearm_edges", e, 7);
    joyInL = 4'b1100;
    count_valid(15, n);
    check("s5_armed_multi_no_valid", n, 0);
    check("s5_still_armed", armed, 1);
    joyInL = 4'b1111;
    ticks(10);

    // Reset mid-debounce with the stick held
    joyInL = 4'b0111;
    ticks(3);
    rst_n = 1'b0;
    tick();
    check("s6_rst_valid",  ans_valid,  0);
    check("s6_rst_player", ans_player, 0);
    check("s6_rst_choice", ans_choice, 0);
    check("s6_rst_armed",  armed,      0);
    rst_n = 1'b1;
    count_valid(20, n);
    check("s6_held_no_valid", n, 0);
    check("s6_armed", armed, 1);
    joyInL = 4'b1111;
    ticks(10);
    joyInL = 4'b0111;
    wait_valid(20, e);
    check("s6_latency", e, 7);
    check("s6_player", ans_player, 0);
    check("s6_choice", ans_choice, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
